// File: rtl/if_stage.sv
// if_stage: RV32 instruction fetch with a 2-entry prefetch FIFO.
// Ports: clk, rst (async, active-high); imem_req/imem_addr/imem_gnt/
// imem_rvalid/imem_rdata (memory side); redirect/redirect_pc (flush);
// id_valid/id_instr/id_pc/id_ready (decode side).
module if_stage #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        id_valid,
   output logic [31:0] id_instr,
   output logic [31:0] id_pc,
   input  logic        id_ready
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_REQ,
      S_WAIT,
      S_DROP
   } state_e;

   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] opc_q, opc_d;
   logic [1:0]  cnt_q, cnt_d;
   logic [31:0] h_pc_q, h_pc_d;
   logic [31:0] h_ins_q, h_ins_d;
   logic [31:0] t_pc_q, t_pc_d;
   logic [31:0] t_ins_q, t_ins_d;

   logic push;
   logic pop;

   // Low target bits are ignored by design.
   logic unused_rpc_lsb;
   assign unused_rpc_lsb = ^redirect_pc[1:0];

   assign id_valid  = (cnt_q != 2'd0);
   assign id_instr  = id_valid ? h_ins_q : NOP_INSTR;
   assign id_pc     = id_valid ? h_pc_q : pc_q;
   assign imem_addr = pc_q;

   assign push = (state_q == S_WAIT) & imem_rvalid & ~redirect;
   assign pop  = id_valid & id_ready & ~redirect;

   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      opc_d    = opc_q;
      cnt_d    = cnt_q;
      h_pc_d   = h_pc_q;
      h_ins_d  = h_ins_q;
      t_pc_d   = t_pc_q;
      t_ins_d  = t_ins_q;
      imem_req = 1'b0;

      // FIFO: head is entry h, tail is entry t.
      if (push && pop) begin
         if (cnt_q == 2'd1) begin
            h_pc_d  = opc_q;
            h_ins_d = imem_rdata;
         end else begin
            h_pc_d  = t_pc_q;
            h_ins_d = t_ins_q;
            t_pc_d  = opc_q;
            t_ins_d = imem_rdata;
         end
      end else if (pop) begin
         h_pc_d  = t_pc_q;
         h_ins_d = t_ins_q;
         cnt_d   = cnt_q - 2'd1;
      end else if (push) begin
         if (cnt_q == 2'd0) begin
            h_pc_d  = opc_q;
            h_ins_d = imem_rdata;
         end else begin
            t_pc_d  = opc_q;
            t_ins_d = imem_rdata;
         end
         cnt_d = cnt_q + 2'd1;
      end

      unique case (state_q)
         S_IDLE: begin
            if (cnt_q < 2'd2) state_d = S_REQ;
         end
         S_REQ: begin
            imem_req = 1'b1;
            if (imem_gnt) begin
               opc_d   = pc_q;
               pc_d    = pc_q + 32'd4;
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            if (imem_rvalid) begin
               state_d = (cnt_d < 2'd2) ? S_REQ : S_IDLE;
            end
         end
         S_DROP: begin
            if (imem_rvalid) state_d = S_REQ;
         end
         default: state_d = S_IDLE;
      endcase

      // Flush wins over everything; a granted or still
      // pending request must be drained in DROP.
      if (redirect) begin
         cnt_d = 2'd0;
         pc_d  = {redirect_pc[31:2], 2'b00};
         unique case (state_q)
            S_IDLE: state_d = S_REQ;
            S_REQ:  state_d = imem_gnt ? S_DROP : S_REQ;
            S_WAIT: state_d = imem_rvalid ? S_REQ : S_DROP;
            S_DROP: state_d = imem_rvalid ? S_REQ : S_DROP;
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         pc_q    <= RESET_PC;
         opc_q   <= RESET_PC;
         cnt_q   <= 2'd0;
         h_pc_q  <= 32'd0;
         h_ins_q <= 32'd0;
         t_pc_q  <= 32'd0;
         t_ins_q <= 32'd0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         opc_q   <= opc_d;
         cnt_q   <= cnt_d;
         h_pc_q  <= h_pc_d;
         h_ins_q <= h_ins_d;
         t_pc_q  <= t_pc_d;
         t_ins_q <= t_ins_d;
      end
   end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-002 Parameter NOP_INSTR, default 32'h0000_0013 (addi x0,x0,0): id_instr value while no instruction is valid.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 imem_req  output  1  fetch request to instruction memory.
REQ-006 imem_addr  output  32  word-aligned fetch address; bits[1:0] always 0.
REQ-007 imem_gnt  input  1  memory accepts the request in this cycle.
REQ-008 imem_rvalid  input  1  imem_rdata is valid this cycle.
REQ-009 imem_rdata  input  32  fetched instruction word.
REQ-010 redirect  input  1  branch/jump taken; flush and refetch.
REQ-011 redirect_pc  input  32  target address; bits[1:0] ignored and treated as 0.
REQ-012 id_valid  output  1  id_instr/id_pc hold a valid instruction for decode.
REQ-013 id_instr  output  32  instruction word for the decode stage (if_id_buffer input).
REQ-014 id_pc  output  32  address of id_instr.
REQ-015 id_ready  input  1  decode consumes the instruction this cycle.

Function
REQ-016 Registered state: pc, 2-entry in-order FIFO of {pc, instr}, entry count (0..2), FSM state, outstanding-pc register.
REQ-017 FSM states: IDLE, REQ, WAIT, DROP; at most one request outstanding at any time.
REQ-018 IDLE: imem_req=0; move to REQ when count + outstanding < 2 (outstanding=0 in IDLE), i.e. count < 2.
REQ-019 REQ: imem_req=1, imem_addr=pc, both held stable until imem_gnt=1; on grant, outstanding-pc <= pc, pc <= pc+4 (32-bit wrap, 32'hFFFF_FFFC+4=0), go to WAIT.
REQ-020 WAIT: imem_req=0; on imem_rvalid push {outstanding-pc, imem_rdata} to FIFO; next state REQ if the resulting count < 2, else IDLE.
REQ-021 Response may arrive one or more cycles after grant; rvalid in the grant cycle is ignored.
REQ-022 Requests are issued only when a FIFO slot is guaranteed (count + outstanding < 2), so a push never overflows.
REQ-023 id_valid = (count != 0); id_instr/id_pc = FIFO head; when count=0, id_instr=NOP_INSTR and id_pc=pc.
REQ-024 Pop when id_valid & id_ready; simultaneous push and pop leaves count unchanged and preserves order.
REQ-025 id_ready with id_valid=0 has no effect.
REQ-026 redirect (highest priority): FIFO emptied (count<=0) and pc <= {redirect_pc[31:2],2'b00} at the next edge; any pop or push that cycle is discarded.
REQ-027 redirect in IDLE or REQ without grant: next state REQ, new pc driven the following cycle.
REQ-028 redirect in REQ with imem_gnt=1, or in WAIT without rvalid: next state DROP.
REQ-029 redirect in WAIT with imem_rvalid=1: response discarded, next state REQ.
REQ-030 DROP: imem_req=0; wait for imem_rvalid, discard the data, go to REQ; a further redirect in DROP updates pc and remains in DROP.
REQ-031 Latency: first instruction at RESET_PC appears on id_valid no earlier than 2 cycles after the grant-to-rvalid delay; sustained throughput one instruction per 2 cycles with 1-cycle memory.

Reset
REQ-032 While rst=1: pc=RESET_PC, count=0, state=IDLE, imem_req=0, imem_addr=RESET_PC, id_valid=0, id_instr=NOP_INSTR, id_pc=RESET_PC.
REQ-033 Reset asserted mid-transaction abandons the outstanding request; a late imem_rvalid after reset release while in IDLE/REQ is ignored.
REQ-034 First request issued in the first cycle after rst deasserts (IDLE -> REQ).

Verification
REQ-035 Reset release, memory grants immediately, rvalid 1 cycle later, id_ready=1 -> id_pc sequence 0x0,0x4,0x8, id_instr matches memory words.
REQ-036 id_ready=0 held -> exactly 2 instructions buffered (id_pc=0x0 held), imem_req stays 0 until a pop.
REQ-037 imem_gnt delayed 3 cycles -> imem_addr stable 0x0 with imem_req=1 throughout; no pc advance.
REQ-038 redirect_pc=0x103 asserted while in WAIT -> pending response discarded, next imem_addr=0x100, next id_pc=0x100, no stale instruction on id_valid.
REQ-039 redirect with simultaneous rvalid and id_ready -> FIFO empty next cycle, id_valid=0, id_instr=0x0000_0013.
REQ-040 rst asserted while in WAIT -> outputs return to reset values asynchronously; after release imem_addr=RESET_PC.
